// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: bit-period table, FSM states, FIFO geometry.
// No logic; imported by the deserializer and its FIFO.
package uart_pkg;

  localparam int FRAME_BITS = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_AW    = 5;
  localparam int CNT_W      = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // Clock cycles per serial bit for each baud-rate select code.
  function automatic logic [CNT_W-1:0] div_of(input logic [1:0] sel);
    logic [CNT_W-1:0] d;
    case (sel)
      2'd0:    d = 13'd5208;
      2'd1:    d = 13'd2604;
      2'd2:    d = 13'd434;
      default: d = 13'd16;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// 32-entry show-ahead byte FIFO with programmable full threshold; write lands one edge after wr_en.
// No backpressure upstream: a write on a full FIFO without a same-cycle read is dropped and flagged.
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  wr_en,
  input  logic [FRAME_BITS-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [5:0]            full_thres,
  output logic [FRAME_BITS-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  overrun
);

  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic [FIFO_AW:0]      count;
  logic [FIFO_AW:0]      thres_eff;
  logic                  do_wr;
  logic                  do_rd;

  // A read frees a slot in the same cycle, so write+read on full both proceed.
  assign do_rd = rd_en && (count != '0);
  assign do_wr = wr_en && ((count != 6'(FIFO_DEPTH)) || do_rd);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 5'd1;
      if (do_rd) rd_ptr <= rd_ptr + 5'd1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: ;
      endcase
      overrun <= wr_en && !do_wr;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign empty     = (count == '0);
  assign rd_data   = empty ? '0 : mem[rd_ptr];
  assign thres_eff = (full_thres == '0) ? 6'(FIFO_DEPTH) : full_thres;
  assign full      = (count >= thres_eff);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver feeding a 32-byte FIFO; byte written one cycle after the stop-bit sample.
// No flow control on the line: bytes arriving on a full FIFO are dropped (overrun pulse).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_receiver
  import uart_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       uart_rx_i,
  input  logic [1:0] baudrate_select_i,
  output logic [7:0] data_o,
  input  logic       data_read_i,
  output logic       data_buffer_empty_o,
  input  logic [5:0] data_buffer_full_thres_i,
  output logic       data_buffer_full_o,
  output logic       frame_error_o,
  output logic       overrun_error_o
);

  logic                  rx_meta;
  logic                  rx_sync;
  logic                  rx_d1;
  logic                  rx_sample;
  rx_state_t             state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [CNT_W-1:0]      div_q, div_n;
  logic [2:0]            bit_idx, bit_n;
  logic [FRAME_BITS-1:0] shift, shift_n;
  logic                  wr_q, wr_n;
  logic                  ferr_n;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_d1   <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_sync <= rx_meta;
      rx_d1   <= rx_sync;
    end
  end

  // The nominal sample is rx_d1 in both builds so frame timing does not change.
`ifdef UART_RX_MAJORITY_EN
  logic rx_d2;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) rx_d2 <= 1'b1;
    else         rx_d2 <= rx_d1;
  end
  assign rx_sample = (rx_sync & rx_d1) | (rx_sync & rx_d2) | (rx_d1 & rx_d2);
`else
  assign rx_sample = rx_d1;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      div_q         <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      wr_q          <= 1'b0;
      frame_error_o <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      div_q         <= div_n;
      bit_idx       <= bit_n;
      shift         <= shift_n;
      wr_q          <= wr_n;
      frame_error_o <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 13'd1;
    div_n   = div_q;
    bit_n   = bit_idx;
    shift_n = shift;
    wr_n    = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_sync) begin
          state_n = ST_START;
          div_n   = div_of(baudrate_select_i);
        end
      end
      ST_START: begin
        if (cnt == {1'b0, div_q[CNT_W-1:1]}) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_sample ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == div_q - 13'd1) begin
          cnt_n   = '0;
          shift_n = {rx_sample, shift[FRAME_BITS-1:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == div_q - 13'd1) begin
          cnt_n = '0;
          if (rx_sample) begin
            wr_n    = 1'b1;
            state_n = ST_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_sync) state_n = ST_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  uart_rx_fifo u_fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .wr_en      (wr_q),
    .wr_data    (shift),
    .rd_en      (data_read_i),
    .full_thres (data_buffer_full_thres_i),
    .rd_data    (data_o),
    .empty      (data_buffer_empty_o),
    .full       (data_buffer_full_o),
    .overrun    (overrun_error_o)
  );

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have port clock_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port uart_rx_i, input, 1 bit: serial line, idle high, asynchronous to clock_i.
REQ-004 SHALL have port baudrate_select_i, input, 2 bits: index into the cycles-per-bit table.
REQ-005 SHALL have port data_o, output, 8 bits: received byte at FIFO head (show-ahead).
REQ-006 SHALL have port data_read_i, input, 1 bit: pop FIFO head this cycle.
REQ-007 SHALL have port data_buffer_empty_o, output, 1 bit: FIFO holds 0 bytes.
REQ-008 SHALL have port data_buffer_full_thres_i, input, 6 bits: fill level at which the buffer is reported full.
REQ-009 SHALL have port data_buffer_full_o, output, 1 bit: FIFO count >= threshold.
REQ-010 SHALL have port frame_error_o, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun_error_o, output, 1 bit: one-cycle pulse when a byte is dropped on a full FIFO.

Function
REQ-012 SHALL pass uart_rx_i through a 2-flop synchronizer before any use.
REQ-013 SHALL use frame 8N1: start 0, 8 data bits LSB first, stop 1.
REQ-014 SHALL use cycles-per-bit DIV: select 0=5208, 1=2604, 2=434, 3=16; selection latched at start detection, changes mid-frame ignored.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE -> START on synchronized line low.
REQ-017 START: sample at DIV/2 cycles; high = false start -> IDLE with no output; low -> DATA.
REQ-018 DATA: sample every DIV cycles, 8 samples shifted LSB first, then -> STOP.
REQ-019 STOP: sample after DIV cycles; high -> write byte to FIFO, -> IDLE; low -> discard byte, pulse frame_error_o, -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE on first synchronized high (break/low-line tolerance).
REQ-021 SHALL write the byte to the FIFO the cycle after the stop sample; data_buffer_empty_o deasserts the cycle after that write.
REQ-022 SHALL provide FIFO depth 32 with a 6-bit count (0..32) and wrapping 5-bit pointers.
REQ-023 data_read_i on empty SHALL be ignored, with no pointer change.
REQ-024 Write on full with no read SHALL drop the byte and pulse overrun_error_o; write plus read in the same cycle on full SHALL both succeed.
REQ-025 data_buffer_full_o SHALL equal count >= threshold, with threshold 0 treated as 32.
REQ-026 Simultaneous read and write on empty SHALL store the byte; the read is ignored.

Reset
REQ-027 reset_i SHALL asynchronously force: state IDLE, counters 0, FIFO count/pointers 0, synchronizer flops 1.
REQ-028 During and after reset SHALL hold data_o=0, data_buffer_empty_o=1, data_buffer_full_o=0, frame_error_o=0, overrun_error_o=0.
REQ-029 Reset mid-frame SHALL abandon the partial byte; the next frame SHALL be received cleanly once the line is high.

Configuration
REQ-030 With UART_RX_MAJORITY_EN defined, each start/data/stop sample SHALL be the 2-of-3 majority of samples at mid-1, mid, mid+1 cycles.
REQ-031 Without UART_RX_MAJORITY_EN, each sample SHALL be the single value at mid; frame timing is identical in both builds.

Structure
REQ-032 Package uart_pkg SHALL hold the DIV table, state enum, FIFO depth (32) and frame width (8).
REQ-033 The FIFO SHALL be sub-module uart_rx_fifo, instantiated once; deserializer FSM at top level.

Verification
REQ-034 Select 3, send 0xAE with no reads -> data_o=0xAE, empty_o=0, no error pulses.
REQ-035 Select 3, 8-cycle low glitch on idle line -> false start, FIFO stays empty, no errors.
REQ-036 Select 3, send 0x55 with stop bit 0 -> frame_error_o one pulse, FIFO empty, state reaches WAIT_HIGH then IDLE.
REQ-037 Threshold 4, send 33 bytes 0x00..0x20 with no reads -> full_o rises at the 4th byte, overrun pulse on the 33rd, reads return 0x00..0x1F in order.
REQ-038 Assert reset_i during DATA of 0xF0, then send 0x3C -> only 0x3C in FIFO.
REQ-039 Select 2, send 0xA5 with ±2% bit-period skew -> 0xA5 received in both macro builds.
